// File: rtl/capture_axi4_writer_pkg.sv
// Shared definitions for the capture stream to AXI4 write-burst packer.
//   state_e        : burst sequencer states
//   AXI_BURST_INCR : AWBURST encoding for incrementing bursts
//   AXI_RESP_OKAY  : BRESP encoding for a successful write
//   AXI_WSTRB_ALL  : full-word write strobe
package capture_axi4_writer_pkg;

  typedef enum logic [1:0] {
    STATE_IDLE = 2'd0,
    STATE_ADDR = 2'd1,
    STATE_DATA = 2'd2,
    STATE_RESP = 2'd3
  } state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [3:0] AXI_WSTRB_ALL  = 4'hF;

endpackage

// File: rtl/capture_fifo.sv
// Synchronous first-word-fall-through FIFO used as the capture stream buffer.
//   clk_i    : clock
//   rst_n_i  : synchronous active-low reset (empties the FIFO)
//   push_i   : write data_i (ignored when full)
//   data_i   : write data
//   pop_i    : drop the head word (ignored when empty)
//   data_o   : head word, valid whenever empty_o is low
//   full_o   : no free entries
//   empty_o  : no stored entries
//   count_o  : number of stored entries (0..DEPTH)
module capture_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    // Push and pop in the same cycle leave the occupancy unchanged.
    if (push_ok && !pop_ok) begin
      count_d = count_q + CW'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/capture_axi4_writer.sv
// Packs a 32-bit capture stream into fixed-length AXI4 INCR write bursts that
// fill a circular memory region. Write-only master, one burst outstanding.
//   clk_i, rst_n_i           : clock, synchronous active-low reset
//   enable_i                 : capture enable; falling edge flushes the buffer
//   cfg_base_i, cfg_size_i   : region base address and size in bytes
//   inport_*                 : valid/ready capture stream input
//   outport_aw*              : AXI4 write address channel
//   outport_w*               : AXI4 write data channel
//   outport_b*               : AXI4 write response channel
//   wr_ptr_o                 : byte offset of the next unwritten word
//   wrapped_o, error_o       : sticky region-wrap and bad-response flags
//   idle_o                   : sequencer idle and buffer empty
module capture_axi4_writer
  import capture_axi4_writer_pkg::*;
#(
  parameter int unsigned BURST_LEN  = 16,
  parameter int unsigned FIFO_DEPTH = 32,
  parameter logic [3:0]  AXI_ID     = 4'd0
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        enable_i,
  input  logic [31:0] cfg_base_i,
  input  logic [31:0] cfg_size_i,
  input  logic        inport_valid_i,
  input  logic [31:0] inport_data_i,
  output logic        inport_ready_o,
  output logic        outport_awvalid_o,
  output logic [31:0] outport_awaddr_o,
  output logic [3:0]  outport_awid_o,
  output logic [7:0]  outport_awlen_o,
  output logic [1:0]  outport_awburst_o,
  input  logic        outport_awready_i,
  output logic        outport_wvalid_o,
  output logic [31:0] outport_wdata_o,
  output logic [3:0]  outport_wstrb_o,
  output logic        outport_wlast_o,
  input  logic        outport_wready_i,
  input  logic        outport_bvalid_i,
  input  logic [1:0]  outport_bresp_i,
  input  logic [3:0]  outport_bid_i,
  output logic        outport_bready_o,
  output logic [31:0] wr_ptr_o,
  output logic        wrapped_o,
  output logic        error_o,
  output logic        idle_o
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  // Wide enough to hold BURST_LEN itself.
  localparam int unsigned LW = $clog2(BURST_LEN) + 1;

  state_e        state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] beat_q, beat_d;
  logic [31:0]   wr_ptr_q, wr_ptr_d;
  logic          wrapped_q, wrapped_d;
  logic          error_q, error_d;

  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [31:0]   fifo_data;
  logic [CW-1:0] fifo_count;

  logic          awvalid, wvalid, wlast, bready;
  logic [31:0]   ptr_next;
  logic          unused_bid;

  assign unused_bid = ^outport_bid_i;

  assign inport_ready_o = !fifo_full && enable_i;
  assign fifo_push      = inport_valid_i && inport_ready_o;
  assign fifo_pop       = wvalid && outport_wready_i;

  capture_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (fifo_push),
    .data_i  (inport_data_i),
    .pop_i   (fifo_pop),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign wlast    = (state_q == STATE_DATA) && (beat_q == len_q - LW'(1));
  assign ptr_next = wr_ptr_q + (32'(len_q) << 2);

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    beat_d    = beat_q;
    wr_ptr_d  = wr_ptr_q;
    wrapped_d = wrapped_q;
    error_d   = error_q;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;

    unique case (state_q)
      STATE_IDLE: begin
        beat_d = '0;
        // The burst length is fixed here; the buffer cannot shrink before the
        // data phase, so W never runs dry mid-burst.
        if (fifo_count >= CW'(BURST_LEN)) begin
          state_d = STATE_ADDR;
          len_d   = LW'(BURST_LEN);
        end else if (!enable_i && !fifo_empty) begin
          state_d = STATE_ADDR;
          len_d   = LW'(fifo_count);
        end
      end
      STATE_ADDR: begin
        awvalid = 1'b1;
        if (outport_awready_i) begin
          state_d = STATE_DATA;
        end
      end
      STATE_DATA: begin
        wvalid = 1'b1;
        if (outport_wready_i) begin
          beat_d = beat_q + LW'(1);
          if (wlast) begin
            state_d = STATE_RESP;
          end
        end
      end
      STATE_RESP: begin
        bready = 1'b1;
        if (outport_bvalid_i) begin
          state_d = STATE_IDLE;
          error_d = error_q | (outport_bresp_i != AXI_RESP_OKAY);
          if (ptr_next == cfg_size_i) begin
            wr_ptr_d  = '0;
            wrapped_d = 1'b1;
          end else begin
            wr_ptr_d = ptr_next;
          end
        end
      end
      default: state_d = STATE_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= STATE_IDLE;
      len_q     <= '0;
      beat_q    <= '0;
      wr_ptr_q  <= '0;
      wrapped_q <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      beat_q    <= beat_d;
      wr_ptr_q  <= wr_ptr_d;
      wrapped_q <= wrapped_d;
      error_q   <= error_d;
    end
  end

  // AW fields derive from registers only, so they hold while awready is low.
  assign outport_awvalid_o = awvalid;
  assign outport_awaddr_o  = cfg_base_i + wr_ptr_q;
  assign outport_awid_o    = AXI_ID;
  assign outport_awlen_o   = 8'(len_q - LW'(1));
  assign outport_awburst_o = AXI_BURST_INCR;

  assign outport_wvalid_o  = wvalid;
  assign outport_wdata_o   = fifo_data;
  assign outport_wstrb_o   = AXI_WSTRB_ALL;
  assign outport_wlast_o   = wlast;

  assign outport_bready_o  = bready;

  assign wr_ptr_o  = wr_ptr_q;
  assign wrapped_o = wrapped_q;
  assign error_o   = error_q;
  assign idle_o    = (state_q == STATE_IDLE) && fifo_empty;

endmodule

// File: tb/tb_capture_axi4_writer.sv
// Bench for capture_axi4_writer: directed stimulus, a queue-based model of the
// stream and the region pointer, and an AXI slave that stalls on request.
module tb_capture_axi4_writer;

  localparam int unsigned BURST_LEN  = 16;
  localparam int unsigned FIFO_DEPTH = 32;
  localparam logic [31:0] BASE       = 32'h1000_0000;
  localparam logic [31:0] SIZE       = 32'h0000_0400;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        awready = 1'b0;
  logic        wready = 1'b0;
  logic        bvalid = 1'b0;
  logic [1:0]  bresp = 2'b00;
  logic [3:0]  bid = 4'd0;

  logic        in_ready, awvalid, wvalid, wlast, bready;
  logic [31:0] awaddr, wdata, wr_ptr;
  logic [3:0]  awid, wstrb;
  logic [7:0]  awlen;
  logic [1:0]  awburst;
  logic        wrapped, error, idle;

  capture_axi4_writer #(
    .BURST_LEN  (BURST_LEN),
    .FIFO_DEPTH (FIFO_DEPTH),
    .AXI_ID     (4'd0)
  ) dut (
    .clk_i             (clk),
    .rst_n_i           (rst_n),
    .enable_i          (enable),
    .cfg_base_i        (BASE),
    .cfg_size_i        (SIZE),
    .inport_valid_i    (in_valid),
    .inport_data_i     (in_data),
    .inport_ready_o    (in_ready),
    .outport_awvalid_o (awvalid),
    .outport_awaddr_o  (awaddr),
    .outport_awid_o    (awid),
    .outport_awlen_o   (awlen),
    .outport_awburst_o (awburst),
    .outport_awready_i (awready),
    .outport_wvalid_o  (wvalid),
    .outport_wdata_o   (wdata),
    .outport_wstrb_o   (wstrb),
    .outport_wlast_o   (wlast),
    .outport_wready_i  (wready),
    .outport_bvalid_i  (bvalid),
    .outport_bresp_i   (bresp),
    .outport_bid_i     (bid),
    .outport_bready_o  (bready),
    .wr_ptr_o          (wr_ptr),
    .wrapped_o         (wrapped),
    .error_o           (error),
    .idle_o            (idle)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
  endtask

  // Model: words buffered but not yet written, burst phase, region pointer.
  logic [31:0] q[$];
  int          phase = 0;           // 0 none, 1 awaiting W beats, 2 awaiting B
  int          m_len = 0;
  int          m_beat = 0;
  logic [31:0] m_ptr = '0;
  logic        m_wrapped = 1'b0;
  logic        m_error = 1'b0;
  bit          b_pend = 1'b0;
  bit          aw_pend = 1'b0;
  logic [31:0] held_addr = '0;
  logic [7:0]  held_len = '0;
  int          bursts_done = 0, aw_count = 0, w_count = 0, stall_cnt = 0;
  int          wlast_at = -1;
  logic [31:0] last_awaddr = '0;
  logic [7:0]  last_awlen = '0;
  bit          checking = 1'b0;

  // Slave behaviour knobs, set by the stimulus.
  int          aw_hold = 0;
  bit          w_random = 1'b0;
  int          err_burst = 0;

  always @(negedge clk) begin
    if (checking) begin
      int exp_len;
      chk("wr_ptr", wr_ptr, m_ptr);
      chk("wrapped", 32'(wrapped), 32'(m_wrapped));
      chk("error", 32'(error), 32'(m_error));
      chk("idle", 32'(idle), 32'(phase == 0 && q.size() == 0));
      chk("in_ready", 32'(in_ready), 32'(enable && q.size() < FIFO_DEPTH));
      chk("wvalid", 32'(wvalid), 32'(phase == 1));
      chk("bready", 32'(bready), 32'(phase == 2));
      if (aw_pend) begin
        chk("aw_hold_valid", 32'(awvalid), 32'd1);
        chk("aw_hold_addr", awaddr, held_addr);
        chk("aw_hold_len", 32'(awlen), 32'(held_len));
      end
      if (awvalid) chk("aw_while_busy", 32'(phase), 32'd0);

      // Slave responses for the coming edge.
      if (awvalid && aw_hold > 0) begin
        awready = 1'b0;
        aw_hold--;
      end else begin
        awready = 1'b1;
      end
      wready = w_random ? 1'($urandom_range(0, 1)) : 1'b1;
      bvalid = b_pend;
      bresp  = (err_burst != 0 && bursts_done + 1 == err_burst) ? 2'b10 : 2'b00;

      if (!rst_n) begin
        q.delete();
        phase = 0; m_len = 0; m_beat = 0;
        m_ptr = '0; m_wrapped = 1'b0; m_error = 1'b0;
        b_pend = 1'b0; aw_pend = 1'b0;
        bursts_done = 0; aw_count = 0; w_count = 0; stall_cnt = 0; wlast_at = -1;
      end else begin
        aw_pend = awvalid && !awready;
        if (aw_pend) begin
          held_addr = awaddr;
          held_len  = awlen;
          stall_cnt++;
        end
        if (awvalid && awready) begin
          exp_len = (q.size() < BURST_LEN) ? q.size() : BURST_LEN;
          chk("awaddr", awaddr, BASE + m_ptr);
          chk("awlen", 32'(awlen), 32'(exp_len - 1));
          chk("awid", 32'(awid), 32'd0);
          chk("awburst", 32'(awburst), 32'd1);
          phase = 1; m_len = int'(awlen) + 1; m_beat = 0;
          aw_count++;
          last_awaddr = awaddr;
          last_awlen  = awlen;
        end
        if (wvalid && wready) begin
          if (q.size() == 0) chk("w_underflow", 32'd1, 32'd0);
          else chk("wdata", wdata, q.pop_front());
          chk("wstrb", 32'(wstrb), 32'hF);
          chk("wlast", 32'(wlast), 32'(m_beat == m_len - 1));
          if (wlast) wlast_at = m_beat;
          m_beat++;
          w_count++;
          if (m_beat == m_len) begin
            phase = 2;
            b_pend = 1'b1;
          end
        end
        if (bvalid && bready) begin
          m_ptr = m_ptr + 32'(m_len * 4);
          if (m_ptr == SIZE) begin
            m_ptr = '0;
            m_wrapped = 1'b1;
          end
          if (bresp != 2'b00) m_error = 1'b1;
          phase = 0;
          b_pend = 1'b0;
          bursts_done++;
        end
        if (in_valid && in_ready) q.push_back(in_data);
      end
    end
  end

  logic [31:0] word_ctr = 32'hA000_0000;

  task automatic push_words(input int n);
    for (int k = 0; k < n; k++) begin
      bit acc = 1'b0;
      in_valid = 1'b1;
      in_data  = word_ctr;
      for (int t = 0; t < 2000 && !acc; t++) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        #1;
      end
      if (!acc) begin
        chk("push_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        return;
      end
      word_ctr = word_ctr + 32'h0000_0101;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_bursts(input int n);
    bit done = 1'b0;
    for (int t = 0; t < 5000 && !done; t++) begin
      @(posedge clk);
      #2;
      done = (bursts_done >= n) && idle;
    end
    if (!done) chk("burst_timeout", 32'(bursts_done), 32'(n));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (checks %0d/%0d)", passed, total);
    $fatal(1);
  end

  initial begin
    @(posedge clk);
    #1;
    checking = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_awvalid", 32'(awvalid), 32'd0);
    chk("rst_wr_ptr", wr_ptr, 32'd0);
    rst_n  = 1'b1;
    enable = 1'b1;

    // 1: single full burst at the base.
    push_words(16);
    wait_bursts(1);
    chk("t1_awaddr", last_awaddr, 32'h1000_0000);
    chk("t1_awlen", 32'(last_awlen), 32'd15);
    chk("t1_wlast_beat", 32'(wlast_at), 32'd15);
    chk("t1_beats", 32'(w_count), 32'd16);
    chk("t1_wr_ptr", wr_ptr, 32'h40);

    // 2: fill the region exactly once, then one more burst after the wrap.
    do_reset();
    push_words(256);
    wait_bursts(16);
    chk("t2_bursts", 32'(aw_count), 32'd16);
    chk("t2_last_addr", last_awaddr, 32'h1000_03C0);
    chk("t2_wr_ptr", wr_ptr, 32'd0);
    chk("t2_wrapped", 32'(wrapped), 32'd1);
    push_words(16);
    wait_bursts(17);
    chk("t2_wrap_addr", last_awaddr, 32'h1000_0000);
    chk("t2_wrap_ptr", wr_ptr, 32'h40);
    chk("t2_still_wrapped", 32'(wrapped), 32'd1);

    // 3: partial flush when capture is disabled.
    do_reset();
    push_words(5);
    repeat (4) @(posedge clk);
    #1;
    chk("t3_no_early_aw", 32'(aw_count), 32'd0);
    enable = 1'b0;
    wait_bursts(1);
    chk("t3_awlen", 32'(last_awlen), 32'd4);
    chk("t3_wr_ptr", wr_ptr, 32'h14);
    chk("t3_idle", 32'(idle), 32'd1);
    chk("t3_wrapped", 32'(wrapped), 32'd0);

    // 4: AW stalled for 20 cycles, W back-pressured randomly.
    do_reset();
    enable   = 1'b1;
    aw_hold  = 20;
    w_random = 1'b1;
    push_words(16);
    wait_bursts(1);
    w_random = 1'b0;
    chk("t4_stall", 32'(stall_cnt), 32'd20);
    chk("t4_aws", 32'(aw_count), 32'd1);
    chk("t4_beats", 32'(w_count), 32'd16);
    chk("t4_wr_ptr", wr_ptr, 32'h40);

    // 5: SLVERR on the second burst is sticky; traffic continues.
    do_reset();
    err_burst = 2;
    push_words(16);
    wait_bursts(1);
    chk("t5_err_b1", 32'(error), 32'd0);
    push_words(16);
    wait_bursts(2);
    chk("t5_err_b2", 32'(error), 32'd1);
    push_words(32);
    wait_bursts(4);
    chk("t5_err_sticky", 32'(error), 32'd1);
    chk("t5_wr_ptr", wr_ptr, 32'h100);
    err_burst = 0;

    // 6: reset in the middle of the data phase.
    do_reset();
    push_words(16);
    begin
      bit hit = 1'b0;
      for (int t = 0; t < 500 && !hit; t++) begin
        @(posedge clk);
        #1;
        hit = (phase == 1 && m_beat == 7);
      end
      chk("t6_reached_beat7", 32'(hit), 32'd1);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("t6_awvalid", 32'(awvalid), 32'd0);
    chk("t6_wvalid", 32'(wvalid), 32'd0);
    chk("t6_bready", 32'(bready), 32'd0);
    chk("t6_wr_ptr", wr_ptr, 32'd0);
    chk("t6_idle", 32'(idle), 32'd1);
    rst_n = 1'b1;
    push_words(16);
    wait_bursts(1);
    chk("t6_clean_addr", last_awaddr, 32'h1000_0000);
    chk("t6_clean_beats", 32'(w_count), 32'd16);
    chk("t6_clean_ptr", wr_ptr, 32'h40);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
